// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared types for the HI/LO multiply/divide unit
// Purpose: operation and FSM state encodings used by mul_div_unit and its bench.
// Ports: none (package).
package md_pkg;

  localparam int MD_OP_W = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE = 3'd0,
    MD_MUL  = 3'd1,
    MD_DIV  = 3'd2,
    MD_MADD = 3'd3,
    MD_MSUB = 3'd4
  } md_op_e;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIN,
    DONE
  } md_state_e;

endpackage

// File: rtl/md_abs_neg.sv
// rtl/md_abs_neg.sv - conditional two's-complement negate
// Purpose: dout = neg ? -din : din. Gives operand magnitudes at capture and
//          re-applies the result sign at commit.
// Ports:
//   neg   in   1      negate when high
//   din   in   WIDTH  value
//   dout  out  WIDTH  din or its two's complement
module md_abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative HI/LO multiply/divide unit for the EX stage
// Purpose: MULT(U), DIV(U), MADD(U), MSUB(U) on sign-magnitude operands with
//          a radix-configurable shift-add multiplier (optional early-out) and a
//          restoring divider. Stalls the pipeline until HI/LO are committed.
// Ports:
//   clk, rst                  clock, async active-low reset
//   reg_flush, reg_stall      abort in-flight op / hold DONE
//   alu_stall                 unit busy, freeze pipeline
//   sign, func                signed operands, md_op_e operation
//   source_a, source_b        multiplicand/dividend, multiplier/divisor
//   hi, lo                    architectural HI/LO
//   hi_write(_data), lo_write(_data)  direct MTHI/MTLO writes
module mul_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MUL_RADIX = 2,
  parameter int EARLY_OUT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reg_flush,
  input  logic               reg_stall,
  output logic               alu_stall,
  input  logic               sign,
  input  logic [MD_OP_W-1:0] func,
  input  logic [WIDTH-1:0]   source_a,
  input  logic [WIDTH-1:0]   source_b,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  input  logic               hi_write,
  input  logic [WIDTH-1:0]   hi_write_data,
  input  logic               lo_write,
  input  logic [WIDTH-1:0]   lo_write_data
);

  localparam int DW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  md_state_e        state, state_d;
  md_op_e           op_q;
  logic             neg_q, neg_r, div0;
  logic [DW-1:0]    acc;
  logic [DW-1:0]    mcand;
  logic [WIDTH-1:0] opb;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [DW-1:0]    pp, mul_sum, div_next, prod, madd_sum, msub_diff;
  logic [WIDTH-1:0] opb_shr, quo, rem;
  logic [WIDTH:0]   rem_sh, diff;
  logic [CNT_W-1:0] cnt_dec;
  logic             op_valid;

  assign op_valid  = (func != MD_NONE);
  // Gated by rst so the pipeline is released as soon as reset asserts.
  assign alu_stall = rst & op_valid & (state != DONE);

  md_abs_neg #(.WIDTH(WIDTH)) u_abs_a (.neg(sign & source_a[WIDTH-1]), .din(source_a), .dout(mag_a));
  md_abs_neg #(.WIDTH(WIDTH)) u_abs_b (.neg(sign & source_b[WIDTH-1]), .din(source_b), .dout(mag_b));

  md_abs_neg #(.WIDTH(DW))    u_fix_p (.neg(neg_q), .din(acc),               .dout(prod));
  md_abs_neg #(.WIDTH(WIDTH)) u_fix_q (.neg(neg_q), .din(acc[WIDTH-1:0]),    .dout(quo));
  md_abs_neg #(.WIDTH(WIDTH)) u_fix_r (.neg(neg_r), .din(acc[DW-1:WIDTH]),   .dout(rem));

  assign cnt_dec   = cnt - CNT_W'(1);
  assign opb_shr   = opb >> MUL_RADIX;
  assign madd_sum  = {hi, lo} + prod;
  assign msub_diff = {hi, lo} - prod;

  // One radix digit of the multiplier: sum of the shifted multiplicand for each set bit.
  always_comb begin
    pp = '0;
    for (int i = 0; i < MUL_RADIX; i++) begin
      if (opb[i]) pp = pp + (mcand << i);
    end
    mul_sum = acc + pp;
  end

  // Restoring divide: acc = {partial remainder, dividend bits / quotient bits}.
  // The remainder stays below the divisor, so the shifted value fits WIDTH+1 bits.
  assign rem_sh   = acc[DW-1:WIDTH-1];
  assign diff     = rem_sh - {1'b0, opb};
  assign div_next = diff[WIDTH] ? {acc[DW-2:0], 1'b0}
                                : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (op_valid) begin
          if (func == MD_DIV) state_d = (source_b == '0) ? FIN : DIV;
          else                state_d = MUL;
        end
      end
      MUL:  if (cnt_dec == '0 || (EARLY_OUT != 0 && opb_shr == '0)) state_d = FIN;
      DIV:  if (cnt_dec == '0) state_d = FIN;
      FIN:  state_d = DONE;
      DONE: if (!reg_stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (reg_flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q  <= MD_NONE;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
      acc   <= '0;
      mcand <= '0;
      opb   <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (!reg_flush) begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            op_q  <= md_op_e'(func);
            neg_q <= sign & (source_a[WIDTH-1] ^ source_b[WIDTH-1]);
            neg_r <= sign & source_a[WIDTH-1];
            opb   <= mag_b;
            if (func == MD_DIV) begin
              cnt  <= CNT_W'(WIDTH);
              div0 <= (source_b == '0);
              // A zero divisor commits the raw dividend, not its magnitude.
              if (source_b == '0) acc <= {source_a, {WIDTH{1'b1}}};
              else                acc <= {{WIDTH{1'b0}}, mag_a};
            end else begin
              cnt   <= CNT_W'(WIDTH / MUL_RADIX);
              div0  <= 1'b0;
              acc   <= '0;
              mcand <= {{WIDTH{1'b0}}, mag_a};
            end
          end
        end
        MUL: begin
          acc   <= mul_sum;
          mcand <= mcand << MUL_RADIX;
          opb   <= opb_shr;
          cnt   <= cnt_dec;
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt_dec;
        end
        FIN: begin
          case (op_q)
            MD_DIV: begin
              if (div0) {hi, lo} <= acc;
              else begin
                hi <= rem;
                lo <= quo;
              end
            end
            MD_MADD: {hi, lo} <= madd_sum;
            MD_MSUB: {hi, lo} <= msub_diff;
            default: {hi, lo} <= prod;
          endcase
        end
        default: ;
      endcase
      if (state != FIN && !op_valid) begin
        if (hi_write) hi <= hi_write_data;
        if (lo_write) lo <= lo_write_data;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_flush, reg_stall, sign;
  logic [2:0]  func, func_eo;
  logic [31:0] source_a, source_b;
  logic        hi_write, lo_write;
  logic [31:0] hi_write_data, lo_write_data;
  logic [31:0] hi, lo, hi_eo, lo_eo;
  logic        alu_stall, alu_stall_eo;

  int checks   = 0;
  int failures = 0;
  int cyc;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32), .MUL_RADIX(2), .EARLY_OUT(0)) dut (
    .clk(clk), .rst(rst), .reg_flush(reg_flush), .reg_stall(reg_stall),
    .alu_stall(alu_stall), .sign(sign), .func(func),
    .source_a(source_a), .source_b(source_b), .hi(hi), .lo(lo),
    .hi_write(hi_write), .hi_write_data(hi_write_data),
    .lo_write(lo_write), .lo_write_data(lo_write_data)
  );

  mul_div_unit #(.WIDTH(32), .MUL_RADIX(2), .EARLY_OUT(1)) dut_eo (
    .clk(clk), .rst(rst), .reg_flush(reg_flush), .reg_stall(reg_stall),
    .alu_stall(alu_stall_eo), .sign(sign), .func(func_eo),
    .source_a(source_a), .source_b(source_b), .hi(hi_eo), .lo(lo_eo),
    .hi_write(hi_write), .hi_write_data(hi_write_data),
    .lo_write(lo_write), .lo_write_data(lo_write_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where alu_stall has dropped (DONE).
  task automatic run_op(input logic [2:0] f, input logic s, input logic [31:0] a,
                        input logic [31:0] b, output int n);
    func = f; sign = s; source_a = a; source_b = b;
    #1;
    n = 0;
    while (alu_stall && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("run_op_timeout", 64'(alu_stall), 64'd0);
  endtask

  task automatic release_op();
    func = MD_NONE;
    @(negedge clk);
  endtask

  task automatic wr_hilo(input logic [31:0] h, input logic [31:0] l);
    hi_write = 1'b1; hi_write_data = h;
    lo_write = 1'b1; lo_write_data = l;
    @(negedge clk);
    hi_write = 1'b0; lo_write = 1'b0;
  endtask

  initial begin
    rst = 1'b0; reg_flush = 1'b0; reg_stall = 1'b0; sign = 1'b0;
    func = MD_NONE; func_eo = MD_NONE; source_a = '0; source_b = '0;
    hi_write = 1'b0; lo_write = 1'b0; hi_write_data = '0; lo_write_data = '0;
    repeat (2) @(negedge clk);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_stall", 64'(alu_stall), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    run_op(MD_MUL, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
    check("mulu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
    check("mulu_cycles", 64'(cyc), 64'd18);
    release_op();

    run_op(MD_MUL, 1'b1, 32'hFFFFFFFD, 32'd7, cyc);
    check("muls_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    release_op();

    func_eo = MD_MUL; sign = 1'b0; source_a = 32'd5; source_b = 32'd1;
    #1;
    cyc = 0;
    while (alu_stall_eo && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("eo_cycles_le3", 64'(cyc <= 3), 64'd1);
    check("eo_result", {hi_eo, lo_eo}, 64'd5);
    func_eo = MD_NONE;
    @(negedge clk);

    run_op(MD_DIV, 1'b1, 32'hFFFFFFF9, 32'd2, cyc);
    check("divs_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    // Still in DONE with func=DIV presented: direct writes must be ignored.
    reg_stall = 1'b1;
    hi_write = 1'b1; hi_write_data = 32'hDEADBEEF;
    lo_write = 1'b1; lo_write_data = 32'h12345678;
    @(negedge clk);
    hi_write = 1'b0; lo_write = 1'b0; reg_stall = 1'b0;
    check("wr_ignored_busy", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    release_op();

    run_op(MD_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, cyc);
    check("divs_min_m1", {hi, lo}, 64'h00000000_80000000);
    check("divs_cycles", 64'(cyc), 64'd34);
    release_op();

    run_op(MD_DIV, 1'b0, 32'd5, 32'd0, cyc);
    check("div_by_zero", {hi, lo}, 64'h00000005_FFFFFFFF);
    check("div0_cycles", 64'(cyc), 64'd2);
    release_op();

    run_op(MD_DIV, 1'b1, 32'hFFFFFFF9, 32'd0, cyc);
    check("div0_signed_raw", {hi, lo}, 64'hFFFFFFF9_FFFFFFFF);
    release_op();

    wr_hilo(32'd0, 32'd10);
    check("direct_write", {hi, lo}, 64'd10);
    run_op(MD_MADD, 1'b0, 32'd3, 32'd4, cyc);
    check("madd", {hi, lo}, 64'd22);
    reg_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_hilo", {hi, lo}, 64'd22);
      check("hold_stall", 64'(alu_stall), 64'd0);
    end
    reg_stall = 1'b0;
    release_op();

    wr_hilo(32'd0, 32'd0);
    run_op(MD_MSUB, 1'b0, 32'd1, 32'd1, cyc);
    check("msub_wrap", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
    release_op();

    wr_hilo(32'h11111111, 32'h22222222);
    func = MD_DIV; sign = 1'b0; source_a = 32'd100; source_b = 32'd7;
    repeat (4) @(negedge clk);
    reg_flush = 1'b1;
    @(negedge clk);
    reg_flush = 1'b0;
    func = MD_NONE;
    #1;
    check("flush_stall", 64'(alu_stall), 64'd0);
    @(negedge clk);
    check("flush_hilo", {hi, lo}, 64'h11111111_22222222);
    run_op(MD_MUL, 1'b0, 32'd6, 32'd7, cyc);
    check("post_flush_mul", {hi, lo}, 64'd42);
    check("post_flush_cycles", 64'(cyc), 64'd18);
    release_op();

    func = MD_MUL; source_a = 32'd3; source_b = 32'd3;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_hilo", {hi, lo}, 64'd0);
    check("async_rst_stall", 64'(alu_stall), 64'd0);
    func = MD_NONE;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
